// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and arctangent table for the rotation
// and vectoring engines.
package cordic_pkg;

    localparam int DW = 18;
    localparam int IW = 5;

    localparam logic [DW-1:0] ANG_PI      = 18'd131072;
    localparam logic [DW-1:0] ANG_HALF_PI = 18'd65536;
    localparam logic [DW-1:0] MAG_MAX     = 18'h3ffff;
    localparam int            K_Q16       = 107922;

    typedef enum logic {
        MODE_ROT = 1'b0,
        MODE_VEC = 1'b1
    } cordic_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } vec_state_t;

    // round(atan(2^-i) * 2^18 / (2*pi))
    function automatic logic [DW-1:0] atan_lut(input logic [IW-1:0] i);
        logic [DW-1:0] a;
        case (i)
            5'd0:    a = 18'd32768;
            5'd1:    a = 18'd19344;
            5'd2:    a = 18'd10221;
            5'd3:    a = 18'd5188;
            5'd4:    a = 18'd2604;
            5'd5:    a = 18'd1303;
            5'd6:    a = 18'd652;
            5'd7:    a = 18'd326;
            5'd8:    a = 18'd163;
            5'd9:    a = 18'd81;
            5'd10:   a = 18'd41;
            5'd11:   a = 18'd20;
            5'd12:   a = 18'd10;
            5'd13:   a = 18'd5;
            5'd14:   a = 18'd3;
            5'd15:   a = 18'd1;
            5'd16:   a = 18'd1;
            default: a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One combinational CORDIC micro-rotation; direction is chosen from
// the sign of y (vectoring) or the sign of z (rotation).
module cordic_micro_rot
    import cordic_pkg::*;
#(
    parameter int W = 24
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic        [DW-1:0] z,
    input  logic        [IW-1:0] i,
    input  cordic_mode_t         mode,
    output logic signed [W-1:0]  x_nxt,
    output logic signed [W-1:0]  y_nxt,
    output logic        [DW-1:0] z_nxt
);

    logic signed [W-1:0] xs;
    logic signed [W-1:0] ys;
    logic        [DW-1:0] a;
    logic                 ccw;

    always_comb begin
        xs  = x >>> i;
        ys  = y >>> i;
        a   = atan_lut(i);
        ccw = (mode == MODE_VEC) ? y[W-1] : ~z[DW-1];
        if (ccw) begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            z_nxt = z - a;
        end else begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + a;
        end
    end

endmodule

// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: (x0, y0) -> gain-scaled magnitude
// and binary-angle phase, one micro-rotation per clock.
module cordic_vec
    import cordic_pkg::*;
#(
    parameter int ITER  = 16,
    parameter int GUARD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] x0,
    input  logic signed [DW-1:0] y0,
    output logic                 busy,
    output logic                 done,
    output logic        [DW-1:0] mag,
    output logic        [DW-1:0] zn
);

    // Two bits above sign cover K*sqrt(2) growth of a full-scale corner.
    localparam int            WI   = DW + GUARD + 3;
    localparam logic [IW-1:0] LAST = IW'(ITER - 1);

    vec_state_t state;
    vec_state_t state_nxt;

    logic signed [WI-1:0] x;
    logic signed [WI-1:0] y;
    logic        [DW-1:0] z;
    logic        [IW-1:0] cnt;
    logic                 zero;

    logic signed [WI-1:0] x0e;
    logic signed [WI-1:0] y0e;
    logic signed [WI-1:0] x_cap;
    logic signed [WI-1:0] y_cap;
    logic        [DW-1:0] z_cap;

    logic signed [WI-1:0] x_nxt;
    logic signed [WI-1:0] y_nxt;
    logic        [DW-1:0] z_nxt;
    logic signed [WI-1:0] xm;
    logic        [DW-1:0] mag_sat;

    logic accept;
    logic last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (cnt == LAST);

    // Left half-plane inputs are folded by 180 degrees first.
    always_comb begin
        x0e = {{(WI-DW){x0[DW-1]}}, x0};
        y0e = {{(WI-DW){y0[DW-1]}}, y0};
        if (x0[DW-1]) begin
            x_cap = (-x0e) <<< GUARD;
            y_cap = (-y0e) <<< GUARD;
            z_cap = ANG_PI;
        end else begin
            x_cap = x0e <<< GUARD;
            y_cap = y0e <<< GUARD;
            z_cap = '0;
        end
    end

    cordic_micro_rot #(
        .W(WI)
    ) u_rot (
        .x     (x),
        .y     (y),
        .z     (z),
        .i     (cnt),
        .mode  (MODE_VEC),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    always_comb begin
        xm = x_nxt >>> GUARD;
        if (zero || xm[WI-1]) begin
            mag_sat = '0;
        end else if (|xm[WI-2:DW]) begin
            mag_sat = MAG_MAX;
        end else begin
            mag_sat = xm[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            z    <= '0;
            cnt  <= '0;
            zero <= 1'b0;
            mag  <= '0;
            zn   <= '0;
        end else if (accept) begin
            x    <= x_cap;
            y    <= y_cap;
            z    <= z_cap;
            cnt  <= '0;
            zero <= (x0 == '0) && (y0 == '0);
        end else if (state == RUN) begin
            x   <= x_nxt;
            y   <= y_nxt;
            z   <= z_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
                mag <= mag_sat;
                zn  <= zero ? '0 : z_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vec.sv
// Bench for cordic_vec: directed table, random vectors against a
// floating-point polar model, held start, reset abort and loopback.
module tb_cordic_vec;

    localparam int  ITER  = 16;
    localparam int  LAT   = ITER + 2;
    localparam real KG    = 1.6467602581210654;
    localparam real TWOPI = 6.283185307179586;
    localparam real ASC   = 262144.0 / TWOPI;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [17:0] x0;
    logic signed [17:0] y0;
    logic               busy;
    logic               done;
    logic        [17:0] mag;
    logic        [17:0] zn;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cordic_vec #(
        .ITER  (ITER),
        .GUARD (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x0    (x0),
        .y0    (y0),
        .busy  (busy),
        .done  (done),
        .mag   (mag),
        .zn    (zn)
    );

    typedef struct {
        int x;
        int y;
        int emag;
        int mtol;
        int ezn;
        int ztol;
    } vec_t;

    vec_t tbl[8];

    function automatic int rnd(real v);
        return $rtoi($floor(v + 0.5));
    endfunction

    function automatic int cdist(int a, int b);
        int d;
        d = (a - b) & 32'h3ffff;
        return (d > 131072) ? 262144 - d : d;
    endfunction

    function automatic int ref_mag(int xi, int yi);
        real r;
        r = KG * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
        if (r > 262143.0) return 262143;
        return rnd(r);
    endfunction

    function automatic int ref_ang(int xi, int yi);
        real a;
        a = $atan2(real'(yi), real'(xi)) * ASC;
        if (a < 0.0) a = a + 262144.0;
        return rnd(a) & 32'h3ffff;
    endfunction

    task automatic chk(input string name, input int act, input int exp,
                       input int tol, input bit circ);
        int d;
        checks++;
        if (circ) d = cdist(act, exp);
        else d = (act > exp) ? act - exp : exp - act;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +/- %0d",
                     name, act, exp, tol);
        end
    endtask

    // Pulses start for one cycle and returns the cycle in which done
    // was first seen, counting the start cycle as cycle 1.
    task automatic run_one(input int xi, input int yi, output int cyc);
        @(negedge clk);
        start = 1'b1;
        x0    = 18'(xi);
        y0    = 18'(yi);
        @(negedge clk);
        start = 1'b0;
        cyc   = 2;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int nd;
        int prev;
        int k;
        int p;
        int hx;
        int hy;
        int xi;
        int yi;
        int hm;
        int ha;
        real r;

        tbl[0] = '{50000,      0,  82338, 4,      0, 2};
        tbl[1] = '{0,      50000,  82338, 4,  65536, 2};
        tbl[2] = '{-50000,     0,  82338, 4, 131072, 2};
        tbl[3] = '{0,     -50000,  82338, 4, 196608, 2};
        tbl[4] = '{-131072, -131072, 262143, 0, 163840, 2};
        tbl[5] = '{0,          0,      0, 0,      0, 0};
        tbl[6] = '{30000, -40000,  82338, 4, 223456, 3};
        tbl[7] = '{-1000,  70000, ref_mag(-1000, 70000), 4,
                   ref_ang(-1000, 70000), 3};

        rst   = 1'b1;
        start = 1'b0;
        x0    = '0;
        y0    = '0;
        #1;
        chk("rst_busy", int'(busy), 0, 0, 0);
        chk("rst_done", int'(done), 0, 0, 0);
        chk("rst_mag",  int'(mag),  0, 0, 0);
        chk("rst_zn",   int'(zn),   0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_one(tbl[t].x, tbl[t].y, cyc);
            chk($sformatf("tbl%0d_lat", t), cyc, LAT, 0, 0);
            chk($sformatf("tbl%0d_mag", t), int'(mag),
                tbl[t].emag, tbl[t].mtol, 0);
            chk($sformatf("tbl%0d_zn", t), int'(zn),
                tbl[t].ezn, tbl[t].ztol, 1);
            if (t == 0) begin
                @(negedge clk);
                chk("done_one_cycle", int'(done), 0, 0, 0);
                chk("busy_after_done", int'(busy), 0, 0, 0);
            end
        end

        for (int n = 0; n < 40; n++) begin
            do begin
                xi = int'($urandom_range(262143, 0)) - 131072;
                yi = int'($urandom_range(262143, 0)) - 131072;
            end while (xi == 0 && yi == 0);
            run_one(xi, yi, cyc);
            chk("rand_lat", cyc, LAT, 0, 0);
            chk($sformatf("rand_mag(%0d,%0d)", xi, yi), int'(mag),
                ref_mag(xi, yi), 6, 0);
            r = $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
            if (r >= 16384.0)
                chk($sformatf("rand_zn(%0d,%0d)", xi, yi), int'(zn),
                    ref_ang(xi, yi), 8, 1);
        end

        // Start held high; inputs scrambled whenever busy.
        hx = 30000;
        hy = 30000;
        hm = ref_mag(hx, hy);
        ha = ref_ang(hx, hy);
        nd = 0;
        prev = 0;
        @(negedge clk);
        start = 1'b1;
        x0 = 18'(hx);
        y0 = 18'(hy);
        for (int c = 2; c <= 60; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("held_spacing", c - prev, LAT, 0, 0);
                chk("held_mag", int'(mag), hm, 4, 0);
                chk("held_zn", int'(zn), ha, 3, 1);
                prev = c;
            end
            if (busy) begin
                x0 = 18'($urandom);
                y0 = 18'($urandom);
            end else begin
                x0 = 18'(hx);
                y0 = 18'(hy);
            end
        end
        start = 1'b0;
        chk("held_count", nd, 3, 0, 0);
        k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("held_drain", int'(busy), 0, 0, 0);

        // Reset during the fifth RUN cycle.
        @(negedge clk);
        start = 1'b1;
        x0 = 18'(50000);
        y0 = 18'(20000);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0, 0, 0);
        chk("abort_done", int'(done), 0, 0, 0);
        chk("abort_mag",  int'(mag),  0, 0, 0);
        chk("abort_zn",   int'(zn),   0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", nd, 0, 0, 0);
        run_one(50000, 20000, cyc);
        chk("post_abort_lat", cyc, LAT, 0, 0);
        chk("post_abort_mag", int'(mag), ref_mag(50000, 20000), 4, 0);
        chk("post_abort_zn", int'(zn), ref_ang(50000, 20000), 3, 1);

        // Oscillator loopback through done -> start, across phase wrap.
        p = 262143 - 3 * 3001;
        for (int n = 0; n < 12; n++) begin
            xi = rnd(50000.0 * $cos(TWOPI * real'(p) / 262144.0));
            yi = rnd(50000.0 * $sin(TWOPI * real'(p) / 262144.0));
            run_one(xi, yi, cyc);
            chk("loop_lat", cyc, LAT, 0, 0);
            chk($sformatf("loop_zn_p%0d", p), int'(zn), p, 3, 1);
            chk("loop_mag", int'(mag), 82338, 4, 0);
            p = (p + 3001) % 262144;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
